// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes and channel FSM states.
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational address decoder: maps a byte address to {hit, register index}.
module axil_addr_decode #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  localparam int         IDX_W     = $clog2(NUM_REGS)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

  logic [31:0] offset;
  logic        unused_offset;

  // Comparing the offset rather than BASE_ADDR+SPAN avoids wrap at the top of the map.
  assign offset        = addr - BASE_ADDR;
  assign hit           = (addr >= BASE_ADDR) && (offset < SPAN);
  assign idx           = offset[IDX_W+1:2];
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers as flat outputs.
// Define AXIL_REG_SLAVE_STATUS_EN to make the last register a read-only view of status_i.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [31:0]              s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
`ifdef AXIL_REG_SLAVE_STATUS_EN
  input  logic [31:0]              status_i,
`endif
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam int             IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  wr_state_t        wr_state, wr_next;
  rd_state_t        rd_state, rd_next;
  logic             aw_held, w_held, aw_hs, w_hs, ar_hs;
  logic [31:0]      awaddr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic             w_hit, r_hit, w_ro, w_commit;
  logic [IDX_W-1:0] w_idx, r_idx;
  resp_t            w_resp;
  logic [31:0]      rd_value;
  logic [31:0]      regs_q [NUM_REGS];

  axil_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_wr_decode (
    .addr (awaddr_q),
    .hit  (w_hit),
    .idx  (w_idx)
  );

  axil_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_rd_decode (
    .addr (s_axi_araddr),
    .hit  (r_hit),
    .idx  (r_idx)
  );

  // Readies are held low while reset is asserted.
  assign s_axi_awready = aresetn && (wr_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = aresetn && (wr_state == W_IDLE) && !w_held;
  assign s_axi_arready = aresetn && (rd_state == R_IDLE);
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;

`ifdef AXIL_REG_SLAVE_STATUS_EN
  assign w_ro = w_hit && (w_idx == LAST_IDX);
`else
  assign w_ro = 1'b0;
`endif

  always_comb begin
    wr_next    = wr_state;
    w_resp     = RESP_OKAY;
    w_commit   = 1'b0;
    wr_pulse_o = '0;
    case (wr_state)
      W_IDLE: if (aw_held && w_held) wr_next = W_EXEC;
      W_EXEC: begin
        wr_next = W_RESP;
        if (!w_hit) begin
          w_resp = RESP_DECERR;
        end else if (w_ro) begin
          w_resp = RESP_SLVERR;
        end else begin
          w_commit = 1'b1;
          if (wstrb_q != 4'b0000) wr_pulse_o[w_idx] = 1'b1;
        end
      end
      W_RESP: if (s_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  // Write payload capture; only the held flags qualify it, so no reset is needed.
  always_ff @(posedge aclk) begin
    if (aw_hs) awaddr_q <= s_axi_awaddr;
    if (w_hs) begin
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (wr_state == W_EXEC) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= w_resp;
        if (w_commit) begin
          for (int k = 0; k < 4; k++)
            if (wstrb_q[k]) regs_q[w_idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end else if ((wr_state == W_RESP) && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (s_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_value = r_hit ? regs_q[r_idx] : 32'h0;
`ifdef AXIL_REG_SLAVE_STATUS_EN
    if (r_hit && (r_idx == LAST_IDX)) rd_value = status_i;
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state     <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_value;
        s_axi_rresp  <= r_hit ? RESP_OKAY : RESP_DECERR;
      end else if ((rd_state == R_DATA) && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs_q[i];
`ifdef AXIL_REG_SLAVE_STATUS_EN
    regs_o[32*(NUM_REGS-1) +: 32] = status_i;
`endif
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: handshake timing, strobes, decode errors, back-pressure, reset.
module tb_axil_reg_slave;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] BASE     = 32'h0001_0000;

  logic                   aclk;
  logic                   aresetn;
  logic [31:0]            s_axi_awaddr;
  logic                   s_axi_awvalid;
  logic                   s_axi_awready;
  logic [31:0]            s_axi_wdata;
  logic [3:0]             s_axi_wstrb;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [1:0]             s_axi_bresp;
  logic                   s_axi_bvalid;
  logic                   s_axi_bready;
  logic [31:0]            s_axi_araddr;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [31:0]            s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;
  logic [31:0]            status_i;
  logic [NUM_REGS*32-1:0] regs_o;
  logic [NUM_REGS-1:0]    wr_pulse_o;

  int checks = 0;
  int errors = 0;

  axil_reg_slave #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
`ifdef AXIL_REG_SLAVE_STATUS_EN
    .status_i      (status_i),
`endif
    .regs_o        (regs_o),
    .wr_pulse_o    (wr_pulse_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_o[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int bdelay, input logic [1:0] exp_resp, input logic [31:0] exp_pulse,
                          input string tag);
    logic [NUM_REGS-1:0] pulses;
    logic aw_hs, w_hs;
    int n;
    pulses        = '0;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      pulses |= wr_pulse_o;
      tick();
      n++;
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid  = 1'b0;
    end
    if (s_axi_awvalid || s_axi_wvalid) begin
      check({tag, "_addr_timeout"}, 32'd0, 32'd1);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      return;
    end
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      pulses |= wr_pulse_o;
      tick();
      n++;
    end
    if (!s_axi_bvalid) begin
      check({tag, "_b_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
    for (int i = 0; i < bdelay; i++) begin
      tick();
      pulses |= wr_pulse_o;
      check({tag, "_hold_bvalid"}, 32'(s_axi_bvalid), 32'd1);
      check({tag, "_hold_bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
      check({tag, "_hold_rdy"}, {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check({tag, "_bdrop"}, 32'(s_axi_bvalid), 32'd0);
    check({tag, "_pulse"}, 32'(pulses), exp_pulse);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdelay, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    int n;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      tick();
      n++;
    end
    if (!s_axi_arready) begin
      check({tag, "_ar_timeout"}, 32'd0, 32'd1);
      s_axi_arvalid = 1'b0;
      return;
    end
    tick();
    s_axi_arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
    check({tag, "_rdata"}, s_axi_rdata, exp_data);
    check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
    for (int i = 0; i < rdelay; i++) begin
      tick();
      check({tag, "_hold_rvalid"}, 32'(s_axi_rvalid), 32'd1);
      check({tag, "_hold_rdata"}, s_axi_rdata, exp_data);
      check({tag, "_hold_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
      check({tag, "_hold_arrdy"}, 32'(s_axi_arready), 32'd0);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check({tag, "_rdrop"}, 32'(s_axi_rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    aresetn       = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    status_i      = 32'hCAFE_0001;
    repeat (3) tick();

    check("rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    check("rst_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    check("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_pulse", 32'(wr_pulse_o), 32'd0);
    for (int i = 0; i < NUM_REGS - 1; i++) check("rst_reg", reg_at(i), 32'd0);
    aresetn = 1'b1;
    tick();

    // Same-cycle AW/W: pulse one cycle after the handshake, bvalid two cycles after.
    s_axi_awaddr  = BASE + 32'd4;
    s_axi_wdata   = 32'hDEAD_BEEF;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    check("t1_rdy", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("t1_b_early", 32'(s_axi_bvalid), 32'd0);
    check("t1_pulse_early", 32'(wr_pulse_o), 32'd0);
    tick();
    check("t1_pulse", 32'(wr_pulse_o), 32'h2);
    check("t1_b_exec", 32'(s_axi_bvalid), 32'd0);
    tick();
    check("t1_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("t1_bresp", 32'(s_axi_bresp), 32'd0);
    check("t1_pulse_off", 32'(wr_pulse_o), 32'd0);
    check("t1_reg1", reg_at(1), 32'hDEAD_BEEF);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("t1_bdrop", 32'(s_axi_bvalid), 32'd0);
    do_read(BASE + 32'd4, 0, 32'hDEAD_BEEF, 2'b00, "t1_rd");

    // W leads AW by three cycles with a single byte strobe.
    s_axi_wdata  = 32'h0000_AB00;
    s_axi_wstrb  = 4'b0010;
    s_axi_wvalid = 1'b1;
    check("t2_wrdy", 32'(s_axi_wready), 32'd1);
    tick();
    s_axi_wvalid = 1'b0;
    check("t2_w_held", {30'd0, s_axi_awready, s_axi_wready}, 32'd2);
    tick();
    tick();
    s_axi_awaddr  = BASE + 32'd4;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 10) begin
      tick();
      n++;
    end
    check("t2_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("t2_bresp", 32'(s_axi_bresp), 32'd0);
    check("t2_reg1", reg_at(1), 32'hDEAD_ABEF);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;

    // Zero strobe: OKAY, no change, no pulse.
    do_write(BASE + 32'd4, 32'hFFFF_FFFF, 4'h0, 0, 2'b00, 32'd0, "strb0");
    check("strb0_reg1", reg_at(1), 32'hDEAD_ABEF);

    // Out-of-range accesses just above and below the window.
    do_write(BASE + NUM_REGS * 4, 32'h1111_1111, 4'hF, 0, 2'b11, 32'd0, "t3_wr");
    check("t3_reg1", reg_at(1), 32'hDEAD_ABEF);
    check("t3_reg0", reg_at(0), 32'd0);
    do_read(BASE + NUM_REGS * 4, 0, 32'd0, 2'b11, "t3_rd");
    do_read(BASE - 32'd4, 0, 32'd0, 2'b11, "below_rd");

    // Low address bits ignored.
    do_write(BASE + 32'd31, 32'hA5A5_0F0F, 4'hF, 0, 2'b00, 32'h80, "lowbits");
    check("lowbits_reg7", reg_at(7), 32'hA5A5_0F0F);

    // Back-pressure on both response channels.
    do_write(BASE + 32'd12, 32'h55AA_33CC, 4'hF, 5, 2'b00, 32'h8, "t4_wr");
    do_read(BASE + 32'd12, 5, 32'h55AA_33CC, 2'b00, "t4_rd");

    // Read of reg 2 lands on the same edge that commits its write.
    s_axi_awaddr  = BASE + 32'd8;
    s_axi_wdata   = 32'h1234_5678;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_araddr  = BASE + 32'd8;
    tick();
    check("t5_exec_pulse", 32'(wr_pulse_o), 32'h4);
    check("t5_arrdy", 32'(s_axi_arready), 32'd1);
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check("t5_rvalid", 32'(s_axi_rvalid), 32'd1);
    check("t5_old", s_axi_rdata, 32'd0);
    check("t5_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("t5_reg2", reg_at(2), 32'h1234_5678);
    s_axi_rready = 1'b1;
    s_axi_bready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    check("t5_drop", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    do_read(BASE + 32'd8, 0, 32'h1234_5678, 2'b00, "t5_new");

`ifdef AXIL_REG_SLAVE_STATUS_EN
    do_read(BASE + 32'd60, 0, 32'hCAFE_0001, 2'b00, "st_rd");
    do_write(BASE + 32'd60, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, 32'd0, "st_wr");
    check("st_reg15", reg_at(15), 32'hCAFE_0001);
    do_read(BASE + 32'd60, 0, 32'hCAFE_0001, 2'b00, "st_rd2");
`else
    do_write(BASE + 32'd60, 32'h0BAD_F00D, 4'b1001, 0, 2'b00, 32'h8000, "last_wr");
    check("last_reg15", reg_at(15), 32'h0B00_000D);
    do_read(BASE + 32'd60, 0, 32'h0B00_000D, 2'b00, "last_rd");
`endif

    // Reset while the response is pending: response abandoned, registers cleared.
    s_axi_awaddr  = BASE + 32'd20;
    s_axi_wdata   = 32'h0000_0077;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 10) begin
      tick();
      n++;
    end
    check("t6_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("t6_reg5", reg_at(5), 32'h77);
    aresetn = 1'b0;
    tick();
    check("t6_bdrop", 32'(s_axi_bvalid), 32'd0);
    check("t6_rdy", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    check("t6_reg1", reg_at(1), 32'd0);
    check("t6_reg2", reg_at(2), 32'd0);
    check("t6_reg5", reg_at(5), 32'd0);
    check("t6_reg7", reg_at(7), 32'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_resp", 32'(s_axi_bvalid), 32'd0);
    end
    do_read(BASE + 32'd4, 0, 32'd0, 2'b00, "t6_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite slave (responder) that holds a bank of 32-bit memory-mapped registers.
- It is the peripheral-side counterpart of the CPU's AXI data-port master. It answers the CPU's loads and stores to addresses outside program space.
- Register contents are exported as flat outputs so that GPIO and control logic can consume them.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
- BASE_ADDR, 32'h0001_0000, byte address of register 0; aligned to NUM_REGS*4.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s_axi_awaddr  in  32  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  32  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- regs_o  out  NUM_REGS*32  register contents; reg i at bits [32*i+31:32*i]
- wr_pulse_o  out  NUM_REGS  one-cycle strobe per register written

Behaviour:
- Reset is synchronous, active-low on aresetn; clock is aclk.
- Reset values: all registers 0; all ready/valid outputs 0; bresp, rresp and rdata 0; wr_pulse_o 0.
- Reset mid-transaction abandons the transaction. No response is issued afterwards.
- Decode: hit when BASE_ADDR <= addr < BASE_ADDR+NUM_REGS*4. Index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored.
- Write channel FSM, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE: awready = !aw_held and wready = !w_held, so AW and W are accepted independently in either order or in the same cycle. Each handshake latches its payload and sets the matching held flag. When both flags are set, go to W_EXEC.
  - W_EXEC, one cycle:
    - On a hit, each byte k with wstrb[k]=1 updates; other bytes keep their value.
    - wr_pulse_o[index] is 1 for this cycle only, and only when wstrb != 0.
    - Set bresp = OKAY (2'b00) on a hit, DECERR (2'b11) on a miss. A miss leaves all registers unchanged.
    - Assert bvalid, clear both held flags, go to W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready. On the bready handshake drop bvalid and return to W_IDLE.
  - awready and wready stay 0 in W_EXEC and W_RESP.
- Write latency: bvalid rises 2 cycles after the later of the AW/W handshakes.
- Read channel FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready = 1. On the handshake, register rdata from the current register value (0 on a miss) and set rresp to OKAY or DECERR. Assert rvalid and go to R_DATA.
  - R_DATA: arready = 0. Hold rvalid, rdata and rresp stable until rready, then go to R_IDLE.
  - rvalid rises 1 cycle after the AR handshake. Back-to-back reads achieve one read per 2 cycles.
- Simultaneous events:
  - Read and write channels run fully independently.
  - An AR handshake in the same cycle as W_EXEC to the same register returns the pre-write value.
- Valid outputs never depend combinationally on ready inputs.

Optional Feature:
- Macro: AXIL_REG_SLAVE_STATUS_EN.
- When defined:
  - Add input status_i [31:0].
  - Register NUM_REGS-1 becomes read-only and reads status_i, sampled at the AR handshake.
  - A write to that register returns SLVERR (2'b10), changes nothing and gives no wr_pulse_o.
  - regs_o for that slot carries status_i.
- When undefined: status_i does not exist and all registers are read/write.

Decomposition:
- Package axil_pkg holds:
  - typedef resp_t, 2 bits, with constants RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - enum wr_state_t {W_IDLE, W_EXEC, W_RESP};
  - enum rd_state_t {R_IDLE, R_DATA}.
- One natural sub-module, axil_addr_decode: a combinational helper mapping an address to {hit, index}. It is instantiated once for the write path and once for the read path.

Test Plan:
- Reset release, then write 32'hDEAD_BEEF to BASE+4 with wstrb 4'hF, AW and W in the same cycle -> bresp 00 two cycles later; wr_pulse_o[1] high for 1 cycle; read of BASE+4 returns 32'hDEAD_BEEF with rresp 00.
- W presented 3 cycles before AW with wstrb 4'b0010 and data 32'h0000_AB00 onto reg 1 holding 32'hDEAD_BEEF -> reg 1 becomes 32'hDEAD_ABEF.
- Write and read at BASE+NUM_REGS*4 -> bresp 11, no register change, no wr_pulse_o; rdata 0 with rresp 11.
- Back-pressure: bready held low for 5 cycles and rready held low for 5 cycles -> bvalid/bresp and rvalid/rdata remain stable throughout; awready, wready and arready stay 0 while the responses are pending.
- Read of reg 2 issued in the same cycle as W_EXEC of 32'h1234_5678 to reg 2 (old value 0) -> rdata 0; a subsequent read returns 32'h1234_5678.
- With AXIL_REG_SLAVE_STATUS_EN defined, status_i = 32'hCAFE_0001: read reg NUM_REGS-1 -> 32'hCAFE_0001; write to it -> bresp 10 and the value is unchanged. Separately, aresetn low in W_RESP -> bvalid drops next cycle and all registers clear.
